// File: rtl/game_collision_frame_detector.sv
// Per-frame sprite overlap accumulator: counts spaceship/bullet vs target pixel
// overlaps during a frame and publishes thresholded hit levels at each frame boundary.
module game_collision_frame_detector #(
  parameter int N_TARGETS   = 3,
  parameter int MIN_OVERLAP = 4,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         display_on,
  input  logic                         clear,
  input  logic                         spaceship_rgb_en,
  input  logic                         bullet_rgb_en,
  input  logic [N_TARGETS-1:0]         target_rgb_en,
  output logic                         collision,
  output logic                         collision_bullet,
  output logic [N_TARGETS-1:0]         hit_mask,
  output logic [$clog2(N_TARGETS)-1:0] hit_target,
  output logic                         frame_done
);

  localparam int HT_W = $clog2(N_TARGETS);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_OVERLAP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_WAIT_FRAME, ST_ACCUM} state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     ship_cnt_reg [N_TARGETS];
  logic [CNT_W-1:0]     bul_cnt_reg  [N_TARGETS];
  logic                 collision_reg;
  logic                 collision_bullet_reg;
  logic [N_TARGETS-1:0] hit_mask_reg;
  logic [HT_W-1:0]      hit_target_reg;
  logic                 frame_done_reg;

  logic [N_TARGETS-1:0] ship_ovl;
  logic [N_TARGETS-1:0] bul_ovl;
  logic [N_TARGETS-1:0] ship_hit;
  logic [N_TARGETS-1:0] hit_mask_next;
  logic [HT_W-1:0]      hit_target_next;

  for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_tgt
    assign ship_ovl[gi]      = spaceship_rgb_en & target_rgb_en[gi];
    assign bul_ovl[gi]       = bullet_rgb_en & target_rgb_en[gi];
    assign ship_hit[gi]      = ship_cnt_reg[gi] >= MIN_CNT;
    assign hit_mask_next[gi] = bul_cnt_reg[gi] >= MIN_CNT;
  end

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    hit_target_next = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (hit_mask_next[i]) hit_target_next = HT_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg            <= ST_WAIT_FRAME;
      collision_reg        <= 1'b0;
      collision_bullet_reg <= 1'b0;
      hit_mask_reg         <= '0;
      hit_target_reg       <= '0;
      frame_done_reg       <= 1'b0;
      for (int i = 0; i < N_TARGETS; i++) begin
        ship_cnt_reg[i] <= '0;
        bul_cnt_reg[i]  <= '0;
      end
    end else begin
      frame_done_reg <= 1'b0;
      if (clear) begin
        state_reg            <= ST_WAIT_FRAME;
        collision_reg        <= 1'b0;
        collision_bullet_reg <= 1'b0;
        hit_mask_reg         <= '0;
        hit_target_reg       <= '0;
        for (int i = 0; i < N_TARGETS; i++) begin
          ship_cnt_reg[i] <= '0;
          bul_cnt_reg[i]  <= '0;
        end
      end else begin
        case (state_reg)
          ST_WAIT_FRAME: begin
            // Partial frame after reset/clear is discarded; just arm.
            if (frame_start) begin
              state_reg <= ST_ACCUM;
              for (int i = 0; i < N_TARGETS; i++) begin
                ship_cnt_reg[i] <= '0;
                bul_cnt_reg[i]  <= '0;
              end
            end
          end
          ST_ACCUM: begin
            if (frame_start) begin
              collision_reg        <= |ship_hit;
              collision_bullet_reg <= |hit_mask_next;
              hit_mask_reg         <= hit_mask_next;
              hit_target_reg       <= hit_target_next;
              frame_done_reg       <= 1'b1;
              for (int i = 0; i < N_TARGETS; i++) begin
                ship_cnt_reg[i] <= '0;
                bul_cnt_reg[i]  <= '0;
              end
            end else if (display_on) begin
              for (int i = 0; i < N_TARGETS; i++) begin
                if (ship_ovl[i] && ship_cnt_reg[i] != CNT_MAX)
                  ship_cnt_reg[i] <= ship_cnt_reg[i] + 1'b1;
                if (bul_ovl[i] && bul_cnt_reg[i] != CNT_MAX)
                  bul_cnt_reg[i] <= bul_cnt_reg[i] + 1'b1;
              end
            end
          end
          default: state_reg <= ST_WAIT_FRAME;
        endcase
      end
    end
  end

  assign collision        = collision_reg;
  assign collision_bullet = collision_bullet_reg;
  assign hit_mask         = hit_mask_reg;
  assign hit_target       = hit_target_reg;
  assign frame_done       = frame_done_reg;

endmodule

// File: tb/tb_game_collision_frame_detector.sv
// Randomized + directed bench for game_collision_frame_detector: a frame-level
// reference model queues expected publishes, a negedge monitor checks them.
module tb_game_collision_frame_detector;

  localparam int NT  = 3;
  localparam int MIN = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          display_on = 1'b0;
  logic          clear = 1'b0;
  logic          spaceship_rgb_en = 1'b0;
  logic          bullet_rgb_en = 1'b0;
  logic [NT-1:0] target_rgb_en = '0;
  logic          collision;
  logic          collision_bullet;
  logic [NT-1:0] hit_mask;
  logic [1:0]    hit_target;
  logic          frame_done;

  always #5 clk = ~clk;

  game_collision_frame_detector #(
    .N_TARGETS(NT), .MIN_OVERLAP(MIN), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .display_on(display_on),
    .clear(clear), .spaceship_rgb_en(spaceship_rgb_en), .bullet_rgb_en(bullet_rgb_en),
    .target_rgb_en(target_rgb_en), .collision(collision),
    .collision_bullet(collision_bullet), .hit_mask(hit_mask),
    .hit_target(hit_target), .frame_done(frame_done)
  );

  typedef struct packed {
    logic          col;
    logic          colb;
    logic [NT-1:0] mask;
    logic [1:0]    tgt;
  } res_t;

  res_t q[$];
  res_t held = '0;
  res_t got;
  int   ship_n[NT];
  int   bul_n[NT];
  bit   armed = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic zero_evt = 1'b1;

  // Model: plain overlap tallies per frame, thresholded at publish time.
  function automatic res_t model_result();
    res_t r;
    bit found;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (ship_n[i] >= MIN) r.col = 1'b1;
      if (bul_n[i] >= MIN) r.mask[i] = 1'b1;
    end
    r.colb = (r.mask != '0);
    for (int i = 0; i < NT; i++) begin
      if (r.mask[i] && !found) begin
        r.tgt = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic zero_tallies();
    for (int i = 0; i < NT; i++) begin
      ship_n[i] = 0;
      bul_n[i]  = 0;
    end
  endtask

  task automatic step(input bit rstn, input bit clr, input bit fs, input bit disp,
                      input bit ship, input bit bul, input logic [NT-1:0] tgt);
    rst = rstn; clear = clr; frame_start = fs; display_on = disp;
    spaceship_rgb_en = ship; bullet_rgb_en = bul; target_rgb_en = tgt;
    if (!rstn || clr) begin
      armed = 1'b0;
      zero_tallies();
    end else if (fs) begin
      if (armed) q.push_back(model_result());
      armed = 1'b1;
      zero_tallies();
    end else if (armed && disp) begin
      for (int i = 0; i < NT; i++) begin
        if (ship && tgt[i]) ship_n[i]++;
        if (bul && tgt[i]) bul_n[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int n, input bit disp, input bit ship, input bit bul,
                     input logic [NT-1:0] tgt);
    for (int k = 0; k < n; k++) step(1, 0, 0, disp, ship, bul, tgt);
  endtask

  task automatic fs_pulse();
    step(1, 0, 1, 1, 0, 0, '0);
  endtask

  always @(posedge clk) zero_evt <= (!rst) || clear;

  always @(negedge clk) begin
    if (zero_evt) begin
      held = '0;
      total++;
      if (frame_done !== 1'b0) begin
        bad++;
        $display("FAIL done_after_clear t=%0t got frame_done=%b want 0", $time, frame_done);
      end
    end else if (frame_done === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done t=%0t got frame_done=1 want 0", $time);
      end else begin
        held = q.pop_front();
      end
    end
    got = {collision, collision_bullet, hit_mask, hit_target};
    total++;
    if (got !== held) begin
      bad++;
      $display("FAIL outputs t=%0t got col=%b colb=%b mask=%b tgt=%0d want col=%b colb=%b mask=%b tgt=%0d",
               $time, got.col, got.colb, got.mask, got.tgt,
               held.col, held.colb, held.mask, held.tgt);
    end
  end

  initial begin
    zero_tallies();
    repeat (3) step(0, 0, 0, 0, 0, 0, '0);

    // Empty frame publishes zeros once
    fs_pulse();
    pix(20, 1, 0, 0, 3'b111);
    pix(5, 1, 1, 0, 3'b000);
    fs_pulse();
    pix(3, 1, 0, 0, '0);

    // Bullet on target 2 (4 px) and target 0 (3 px)
    pix(4, 1, 0, 1, 3'b100);
    pix(3, 1, 0, 1, 3'b001);
    fs_pulse();
    pix(15, 1, 0, 0, '0);
    fs_pulse();
    pix(2, 1, 0, 0, '0);

    // Ship saturates on target 1; bullet on targets 0 and 1
    pix(300, 1, 1, 0, 3'b010);
    pix(5, 1, 0, 1, 3'b011);
    fs_pulse();
    // 257 overlaps must not wrap below threshold
    pix(257, 1, 1, 0, 3'b010);
    fs_pulse();

    // Blanked overlaps and the frame_start cycle itself are not counted
    pix(10, 0, 1, 1, 3'b111);
    pix(3, 1, 0, 1, 3'b001);
    step(1, 0, 1, 1, 1, 1, 3'b111);
    pix(3, 1, 0, 1, 3'b001);
    fs_pulse();
    fs_pulse();
    pix(2, 1, 0, 0, '0);

    // clear beats frame_start; next frame_start only re-arms
    pix(6, 1, 0, 1, 3'b001);
    fs_pulse();
    pix(6, 1, 0, 1, 3'b001);
    step(1, 1, 1, 1, 0, 1, 3'b001);
    pix(6, 1, 0, 1, 3'b001);
    fs_pulse();
    pix(6, 1, 0, 1, 3'b001);
    fs_pulse();
    pix(2, 1, 0, 0, '0);

    // Mid-frame reset while collision is high
    pix(5, 1, 1, 0, 3'b001);
    fs_pulse();
    pix(4, 1, 1, 0, 3'b001);
    step(0, 0, 0, 1, 1, 0, 3'b001);
    pix(4, 1, 1, 0, 3'b001);
    fs_pulse();
    pix(5, 1, 1, 0, 3'b001);
    fs_pulse();

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      int len;
      int sel;
      len = $urandom_range(3, 30);
      for (int c = 0; c < len; c++)
        step(1, 0, 0, ($urandom % 4) != 0, $urandom % 2, $urandom % 2, NT'($urandom));
      sel = $urandom % 10;
      if (sel == 0) step(1, 1, 1, 1, $urandom % 2, $urandom % 2, NT'($urandom));
      else if (sel == 1) begin
        step(1, 0, 1, 1, $urandom % 2, $urandom % 2, NT'($urandom));
        step(1, 0, 1, 1, $urandom % 2, $urandom % 2, NT'($urandom));
      end else if (sel == 2) step(0, 0, 0, 1, 1, 1, 3'b111);
      else step(1, 0, 1, 1, $urandom % 2, $urandom % 2, NT'($urandom));
    end

    pix(3, 1, 0, 0, '0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_done got pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_collision_frame_detector.md
Name: game_collision_frame_detector

Overview:
- Upstream of the game master FSM. Produces its `collision` (spaceship–target) and `collision_bullet` (bullet–target) inputs.
- Accumulates per-pixel sprite overlaps during one raster frame and applies an overlap-count threshold to reject single-pixel glitches.
- At each frame boundary it publishes registered levels, which stay stable for the whole following frame so the FSM can sample them in any state.

Parameters:
- N_TARGETS, 3: number of target sprites.
- MIN_OVERLAP, 4: overlapping pixels per frame needed to declare a hit. Legal range 1..2**CNT_W-1.
- CNT_W, 8: width of each saturating overlap counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- frame_start  in  1  one-cycle pulse at the start of each frame, during blanking.
- display_on  in  1  current pixel is in the visible area.
- clear  in  1  one-cycle request from the FSM side at round start; discards accumulated and published results.
- spaceship_rgb_en  in  1  spaceship drives the current pixel.
- bullet_rgb_en  in  1  bullet drives the current pixel.
- target_rgb_en  in  N_TARGETS  target i drives the current pixel.
- collision  out  1  spaceship overlapped at least one target in the last completed frame.
- collision_bullet  out  1  bullet overlapped at least one target in the last completed frame.
- hit_mask  out  N_TARGETS  bit i set when the bullet overlapped target i in the last completed frame.
- hit_target  out  $clog2(N_TARGETS)  lowest index set in hit_mask; 0 when hit_mask is 0.
- frame_done  out  1  one-cycle pulse when new results are published.

Behaviour:
- Reset (rst==0): state=ST_WAIT_FRAME; all counters 0; collision, collision_bullet, hit_mask, hit_target and frame_done all 0.
- ST_WAIT_FRAME:
  - Pixels are ignored and outputs hold.
  - On frame_start: go to ST_ACCUM, all counters 0, no publish.
  - This discards the partial frame seen after reset or clear.
- ST_ACCUM, per cycle with display_on==1 and frame_start==0:
  - ship_cnt[i] increments when spaceship_rgb_en & target_rgb_en[i].
  - bul_cnt[i] increments when bullet_rgb_en & target_rgb_en[i].
  - Both counters saturate at 2**CNT_W-1 and never wrap.
  - Spaceship–bullet overlap is not counted.
- ST_ACCUM, on frame_start:
  - Publish on the next clock edge: collision = OR_i(ship_cnt[i] >= MIN_OVERLAP); hit_mask[i] = (bul_cnt[i] >= MIN_OVERLAP); collision_bullet = |hit_mask; hit_target = priority encode of hit_mask, lowest index first.
  - Pulse frame_done=1 for exactly one cycle.
  - Zero all counters the same edge; stay in ST_ACCUM.
  - The frame_start cycle itself is never counted.
- Latency: results are visible 1 cycle after frame_start and held until the next publish, clear or reset.
- Both collision and collision_bullet may be 1 together; priority between them is resolved downstream.
- clear:
  - Next edge: outputs 0, counters 0, frame_done 0, state=ST_WAIT_FRAME.
  - clear has priority over a simultaneous frame_start; that frame is neither published nor accumulated.
- Any X-free input combination is legal. Pixels with display_on==0 are never counted.
- Reset mid-frame behaves exactly like power-on reset.
- frame_start pulses closer than 1 cycle apart do not occur. Back-to-back frame_start on consecutive cycles publishes a second, empty frame (all zeros).
- Counter arithmetic is unsigned CNT_W. The comparison is against the MIN_OVERLAP constant only; no subtraction.

Test Plan:
- Reset, then frame_start, a frame with no overlaps, frame_start -> frame_done pulses once 1 cycle after the second frame_start; collision=0, collision_bullet=0, hit_mask=3'b000.
- In one frame, bullet overlaps target 2 for 4 visible pixels and target 0 for 3 pixels -> after publish hit_mask=3'b100, hit_target=2, collision_bullet=1, collision=0. Values hold through the entire next empty frame, then drop to 0 at the following publish.
- Spaceship overlaps target 1 for 300 pixels (counter saturates at 255) while bullet overlaps target 0 and target 1 for 5 pixels each -> collision=1, collision_bullet=1, hit_mask=3'b011, hit_target=0.
- 10 overlapping pixels with display_on=0, plus an overlap on the frame_start cycle -> none counted; all outputs 0 after publish.
- clear asserted in the same cycle as frame_start after a frame with 6 bullet–target-0 pixels -> no frame_done, outputs 0. The next frame_start only re-arms (no publish); the frame after that publishes normally.
- rst=0 for 1 cycle mid-frame while collision=1 -> all outputs 0 next cycle. The first frame_start after reset produces no frame_done; the second one does.
